// File: rtl/rv64_ctrl_pkg.sv
// rv64_ctrl_pkg: shared types, opcodes and helpers for the RV64I pipeline control blocks
package rv64_ctrl_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  typedef enum logic {MS_IDLE, MS_WAIT} mem_state_e;
  localparam logic [6:0] LOAD   = 7'd3;
  localparam logic [6:0] STORE  = 7'd35;
  localparam logic [6:0] BRANCH = 7'd99;
  localparam logic [6:0] JAL    = 7'd111;
  localparam logic [6:0] JALR   = 7'd103;
  // A later stage can supply src only if it writes a non-x0 register equal to src.
  function automatic logic fwd_hit(input logic wr, input logic [4:0] rd, input logic [4:0] src);
    return wr && rd != 5'd0 && rd == src;
  endfunction
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: forwarding select for one EX operand
//   src_i                 register read by the operand in EX
//   mem_rd_i/mem_reg_wr_i destination and write flag of the MEM stage
//   wb_rd_i/wb_reg_wr_i   destination and write flag of the WB stage
//   fwd_o                 FWD_MEM, FWD_WB or FWD_RF (MEM is newer and wins)
module fwd_unit
  import rv64_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_wr_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_wr_i,
  output logic [1:0] fwd_o
);
  assign fwd_o = fwd_hit(mem_reg_wr_i, mem_rd_i, src_i) ? FWD_MEM :
                 fwd_hit(wb_reg_wr_i, wb_rd_i, src_i)   ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables, flushes, forwarding and dmem handshake for the 5-stage core
//   clk, rst (async, active high)
//   id_*    source registers of the instruction in ID
//   ex_*    destination/load/redirect info of the instruction in EX
//   mem_*   destination and access info of MEM; wb_* destination of WB
//   dmem_ready_i / dmem_req_o   data memory handshake
//   pc_en_o, *_en_o, *_flush_o, mem_wb_bubble_o   pipeline register control
//   fwd_a_o/fwd_b_o   operand forwarding selects for EX
//   stall_cycles_o, flush_count_o   saturating perf counters; mem_err_o sticky timeout
module pipe_hazard_ctrl
  import rv64_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_wr_i,
  input  logic             ex_dmem_rd_i,
  input  logic             ex_pc_src_i,
  input  logic             ex_jump_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             mem_reg_wr_i,
  input  logic             wb_reg_wr_i,
  input  logic             mem_valid_i,
  input  logic             mem_dmem_rd_i,
  input  logic             mem_dmem_wr_i,
  input  logic             dmem_ready_i,
  output logic             dmem_req_o,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_bubble_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic             mem_err_o
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  mem_state_e       state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             err_q, err_d;
  logic [4:0]       ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic             mem_acc, in_wait, timeout, mem_stall, redirect, load_use;
  logic             pc_en, id_ex_en, if_id_flush, id_ex_flush;
  logic [1:0]       fwd_a, fwd_b;
  always_comb begin
    mem_acc     = mem_valid_i & (mem_dmem_rd_i | mem_dmem_wr_i);
    in_wait     = state_q == MS_WAIT;
    // Timeout releases the stall in the same cycle; the access is dropped.
    timeout     = in_wait & ~dmem_ready_i & (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));
    mem_stall   = in_wait ? ~dmem_ready_i & ~timeout : mem_acc & ~dmem_ready_i;
    redirect    = ex_pc_src_i | ex_jump_i;
    load_use    = ex_dmem_rd_i & ex_reg_wr_i & (ex_rd_i != 5'd0) &
                  ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    // Redirect squashes the ID instruction, so it overrides a load-use stall.
    pc_en       = ~mem_stall & (redirect | ~load_use);
    id_ex_en    = ~mem_stall;
    if_id_flush = ~mem_stall & redirect;
    id_ex_flush = ~mem_stall & (redirect | load_use);
    state_d     = (in_wait ? ~(dmem_ready_i | timeout) : mem_stall) ? MS_WAIT : MS_IDLE;
    wait_cnt_d  = (in_wait & mem_stall) ? wait_cnt_q + 1'b1 : '0;
    err_d       = err_q | timeout;
    stall_d     = (~pc_en & ~&stall_q) ? stall_q + 1'b1 : stall_q;
    flush_d     = (redirect & ~mem_stall & ~&flush_q) ? flush_q + 1'b1 : flush_q;
    ex_rs1_d    = id_ex_flush ? 5'd0 : id_ex_en ? id_rs1_i : ex_rs1_q;
    ex_rs2_d    = id_ex_flush ? 5'd0 : id_ex_en ? id_rs2_i : ex_rs2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MS_IDLE;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      err_q      <= 1'b0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      err_q      <= err_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
    end
  end
  fwd_unit u_fwd_a (
    .src_i        (ex_rs1_q),
    .mem_rd_i     (mem_rd_i),
    .mem_reg_wr_i (mem_reg_wr_i),
    .wb_rd_i      (wb_rd_i),
    .wb_reg_wr_i  (wb_reg_wr_i),
    .fwd_o        (fwd_a)
  );
  fwd_unit u_fwd_b (
    .src_i        (ex_rs2_q),
    .mem_rd_i     (mem_rd_i),
    .mem_reg_wr_i (mem_reg_wr_i),
    .wb_rd_i      (wb_rd_i),
    .wb_reg_wr_i  (wb_reg_wr_i),
    .fwd_o        (fwd_b)
  );
  // Reset forces a safe control vector immediately, independent of the clock.
  always_comb begin
    dmem_req_o      = ~rst & (in_wait | mem_acc);
    pc_en_o         = ~rst & pc_en;
    if_id_en_o      = ~rst & pc_en;
    id_ex_en_o      = ~rst & id_ex_en;
    ex_mem_en_o     = ~rst & id_ex_en;
    if_id_flush_o   = rst | if_id_flush;
    id_ex_flush_o   = rst | id_ex_flush;
    mem_wb_bubble_o = rst | mem_stall;
    fwd_a_o         = rst ? FWD_RF : fwd_a;
    fwd_b_o         = rst ? FWD_RF : fwd_b;
  end
  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;
  assign mem_err_o      = err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed spec scenarios plus random traffic against a scoreboarded reference model
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam int TO = 4;
  localparam int SAT = (1 << CW) - 1;
  typedef struct {
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_reg_wr, ex_dmem_rd, ex_pc_src, ex_jump;
    logic mem_reg_wr, wb_reg_wr, mem_valid, mem_dmem_rd, mem_dmem_wr, dmem_ready;
  } stim_t;
  typedef struct {
    logic [7:0] ctl;
    logic [1:0] fa, fb;
    int st, fl;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_wr, ex_dmem_rd, ex_pc_src, ex_jump;
  logic mem_reg_wr, wb_reg_wr, mem_valid, mem_dmem_rd, mem_dmem_wr, dmem_ready;
  logic dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, bubble, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cycles, flush_count;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  bit m_wait;
  int m_wcnt, m_stall, m_flush, m_src1, m_src2;
  bit m_err;
  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rd_i(ex_rd), .ex_reg_wr_i(ex_reg_wr), .ex_dmem_rd_i(ex_dmem_rd),
    .ex_pc_src_i(ex_pc_src), .ex_jump_i(ex_jump),
    .mem_rd_i(mem_rd), .wb_rd_i(wb_rd), .mem_reg_wr_i(mem_reg_wr), .wb_reg_wr_i(wb_reg_wr),
    .mem_valid_i(mem_valid), .mem_dmem_rd_i(mem_dmem_rd), .mem_dmem_wr_i(mem_dmem_wr),
    .dmem_ready_i(dmem_ready), .dmem_req_o(dmem_req),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush),
    .id_ex_en_o(id_ex_en), .id_ex_flush_o(id_ex_flush), .ex_mem_en_o(ex_mem_en),
    .mem_wb_bubble_o(bubble), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .stall_cycles_o(stall_cycles), .flush_count_o(flush_count), .mem_err_o(mem_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask
  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.dmem_ready = 1'b1;
    return s;
  endfunction
  function automatic int fsel(input int src, input stim_t s);
    if (src == 0) return 0;
    if (s.mem_reg_wr && s.mem_rd == src) return 2;
    if (s.wb_reg_wr && s.wb_rd == src) return 1;
    return 0;
  endfunction
  function automatic int sat(input int v);
    return v > SAT ? SAT : v;
  endfunction
  task automatic model(input stim_t s, output exp_t e);
    bit acc, tmo, stl, redir, lu;
    bit p, ie, ifl, xe, xfl, me, bb;
    if (s.rst) begin
      m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_err = 0; m_src1 = 0; m_src2 = 0;
      e.ctl = 8'b0010_1010;
      e.fa = 0; e.fb = 0; e.st = 0; e.fl = 0; e.err = 0;
      return;
    end
    acc   = s.mem_valid && (s.mem_dmem_rd || s.mem_dmem_wr);
    tmo   = m_wait && m_wcnt == TO - 1 && !s.dmem_ready;
    stl   = m_wait ? (!s.dmem_ready && !tmo) : (acc && !s.dmem_ready);
    redir = s.ex_pc_src || s.ex_jump;
    lu    = s.ex_dmem_rd && s.ex_reg_wr && s.ex_rd != 0 &&
            ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
    if (stl) begin
      p = 0; ie = 0; ifl = 0; xe = 0; xfl = 0; me = 0; bb = 1;
    end else if (redir) begin
      p = 1; ie = 1; ifl = 1; xe = 1; xfl = 1; me = 1; bb = 0;
    end else if (lu) begin
      p = 0; ie = 0; ifl = 0; xe = 1; xfl = 1; me = 1; bb = 0;
    end else begin
      p = 1; ie = 1; ifl = 0; xe = 1; xfl = 0; me = 1; bb = 0;
    end
    e.ctl = {p, ie, ifl, xe, xfl, me, bb, m_wait || acc};
    e.fa  = 2'(fsel(m_src1, s));
    e.fb  = 2'(fsel(m_src2, s));
    e.st  = m_stall;
    e.fl  = m_flush;
    e.err = m_err;
    if (!p) m_stall = sat(m_stall + 1);
    if (redir && !stl) m_flush = sat(m_flush + 1);
    if (tmo) m_err = 1;
    if (m_wait) begin
      if (s.dmem_ready || tmo) begin m_wait = 0; m_wcnt = 0; end
      else m_wcnt++;
    end else if (stl) begin
      m_wait = 1; m_wcnt = 0;
    end
    if (xfl) begin m_src1 = 0; m_src2 = 0; end
    else if (xe) begin m_src1 = s.id_rs1; m_src2 = s.id_rs2; end
  endtask
  task automatic cyc(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_use_rs1 = s.id_use_rs1; id_use_rs2 = s.id_use_rs2;
    ex_rd = s.ex_rd; ex_reg_wr = s.ex_reg_wr; ex_dmem_rd = s.ex_dmem_rd; ex_pc_src = s.ex_pc_src; ex_jump = s.ex_jump;
    mem_rd = s.mem_rd; wb_rd = s.wb_rd; mem_reg_wr = s.mem_reg_wr; wb_reg_wr = s.wb_reg_wr;
    mem_valid = s.mem_valid; mem_dmem_rd = s.mem_dmem_rd; mem_dmem_wr = s.mem_dmem_wr; dmem_ready = s.dmem_ready;
    #1;
    model(s, e);
    sb.push_back(e);
  endtask
  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    cyc(s);
    s.rst = 1'b0;
    cyc(s);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ctl", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, bubble, dmem_req}, e.ctl);
      chk("fwd_a", fwd_a, e.fa);
      chk("fwd_b", fwd_b, e.fb);
      chk("stall_cycles", stall_cycles, e.st);
      chk("flush_count", flush_count, e.fl);
      chk("mem_err", mem_err, e.err);
    end
  end
  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    cyc(s);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_if_id_flush", if_id_flush, 1);
    chk("rst_id_ex_flush", id_ex_flush, 1);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_stall", stall_cycles, 0);
    s.rst = 1'b0;
    cyc(s);
    // load-use: LD x5 in EX, ADD x6,x5,x7 in ID
    s = idle();
    s.ex_rd = 5; s.ex_dmem_rd = 1; s.ex_reg_wr = 1;
    s.id_rs1 = 5; s.id_rs2 = 7; s.id_use_rs1 = 1; s.id_use_rs2 = 1;
    cyc(s);
    chk("lu_pc_en", pc_en, 0);
    chk("lu_if_id_en", if_id_en, 0);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_ex_mem_en", ex_mem_en, 1);
    s.ex_rd = 0; s.ex_dmem_rd = 0; s.ex_reg_wr = 0; s.mem_rd = 5; s.mem_reg_wr = 1;
    cyc(s);
    chk("lu_stall_cycles", stall_cycles, 1);
    cyc(s);
    chk("lu_fwd_a", fwd_a, 2);
    // taken branch while ID holds a load-use pair
    do_reset();
    s = idle();
    s.ex_rd = 5; s.ex_dmem_rd = 1; s.ex_reg_wr = 1; s.ex_pc_src = 1;
    s.id_rs1 = 5; s.id_use_rs1 = 1;
    cyc(s);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    chk("br_pc_en", pc_en, 1);
    cyc(idle());
    chk("br_flush_count", flush_count, 1);
    chk("br_stall_cycles", stall_cycles, 0);
    // store waits three cycles for memory
    do_reset();
    s = idle();
    s.mem_valid = 1; s.mem_dmem_wr = 1;
    for (int i = 0; i < 4; i++) begin
      s.dmem_ready = (i == 3);
      cyc(s);
      chk("mw_dmem_req", dmem_req, 1);
      chk("mw_pc_en", pc_en, i == 3);
      chk("mw_ex_mem_en", ex_mem_en, i == 3);
    end
    cyc(idle());
    chk("mw_stall_cycles", stall_cycles, 3);
    // memory never answers: timeout after TO wait cycles
    do_reset();
    s = idle();
    s.mem_valid = 1; s.mem_dmem_rd = 1; s.dmem_ready = 0;
    for (int i = 0; i <= TO; i++) begin
      cyc(s);
      chk("to_pc_en", pc_en, i == TO);
      chk("to_err_early", mem_err, 0);
    end
    cyc(idle());
    chk("to_mem_err", mem_err, 1);
    chk("to_dmem_req", dmem_req, 0);
    chk("to_pc_en_resume", pc_en, 1);
    // reset in the middle of a wait
    cyc(s);
    cyc(s);
    s.rst = 1'b1;
    cyc(s);
    chk("rw_pc_en", pc_en, 0);
    chk("rw_id_ex_en", id_ex_en, 0);
    chk("rw_if_id_flush", if_id_flush, 1);
    chk("rw_dmem_req", dmem_req, 0);
    chk("rw_mem_err", mem_err, 0);
    chk("rw_stall", stall_cycles, 0);
    chk("rw_flush", flush_count, 0);
    cyc(idle());
    chk("rw_idle_req", dmem_req, 0);
    chk("rw_idle_pc_en", pc_en, 1);
    // forwarding priority and x0
    do_reset();
    s = idle();
    s.id_rs1 = 3; s.id_rs2 = 4;
    cyc(s);
    s = idle();
    s.mem_rd = 3; s.wb_rd = 3; s.mem_reg_wr = 1; s.wb_reg_wr = 1;
    cyc(s);
    chk("fw_mem_wins", fwd_a, 2);
    chk("fw_b_rf", fwd_b, 0);
    s.mem_rd = 0; s.wb_rd = 0;
    cyc(s);
    chk("fw_x0", fwd_a, 0);
    s = idle();
    s.id_rs2 = 4;
    cyc(s);
    s = idle();
    s.wb_rd = 4; s.wb_reg_wr = 1; s.mem_rd = 4;
    cyc(s);
    chk("fw_b_wb", fwd_b, 1);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      s.rst         = ($urandom_range(199) == 0);
      s.id_rs1      = 5'($urandom_range(3));
      s.id_rs2      = 5'($urandom_range(3));
      s.ex_rd       = 5'($urandom_range(3));
      s.mem_rd      = 5'($urandom_range(3));
      s.wb_rd       = 5'($urandom_range(3));
      s.id_use_rs1  = 1'($urandom_range(1));
      s.id_use_rs2  = 1'($urandom_range(1));
      s.ex_reg_wr   = 1'($urandom_range(1));
      s.ex_dmem_rd  = 1'($urandom_range(1));
      s.ex_pc_src   = ($urandom_range(7) == 0);
      s.ex_jump     = ($urandom_range(15) == 0);
      s.mem_reg_wr  = 1'($urandom_range(1));
      s.wb_reg_wr   = 1'($urandom_range(1));
      s.mem_valid   = 1'($urandom_range(1));
      s.mem_dmem_rd = 1'($urandom_range(1));
      s.mem_dmem_wr = 1'($urandom_range(1));
      s.dmem_ready  = ($urandom_range(9) < 6);
      cyc(s);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
